ahb2apb_bridge_p: RTL and testbench

Parametrised AHB-Lite to APB3 bridge: single AHB slave port, NUM_SLV APB completers behind a region decoder. Supports APB3 PREADY wait states and PSLVERR, maps slave errors, decode misses and an optional stall watchdog onto the two-cycle AHB ERROR response. Drop-in successor to the fixed 3-slave, 32-bit, zero-wait-state bridge in the AHB peripheral subsystem.

---
 rtl/ahb_apb_pkg.sv | 35 +++
 rtl/apb_region_decoder.sv | 33 +++
 rtl/ahb2apb_bridge_p.sv | 153 +++++++++++++++
 tb/tb_ahb2apb_bridge_p.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
// Shared encodings for the AHB-Lite to APB3 bridge: AHB transfer types,
// AHB response codes, the bridge FSM state set and a transfer-valid helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Completer index width; covers up to 16 APB completers.
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_e;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
    function automatic logic xfer_valid(input logic [1:0] htrans, input logic hreadyin);
        return hreadyin & htrans[1];
    endfunction

endpackage

// File: rtl/apb_region_decoder.sv
// ---------------------------------------------------------------------------
// apb_region_decoder
// Combinational address decoder: splits the APB window starting at BASE_ADDR
// into NUM_SLV regions of 2**REGION_LOG2 bytes each.
// Ports:
//   addr_i  in   ADDR_W  AHB address
//   idx_o   out  IDX_W   completer index (valid only when hit_o=1)
//   hit_o   out  1       address falls inside one of the NUM_SLV regions
// ---------------------------------------------------------------------------
module apb_region_decoder
    import ahb_apb_pkg::*;
#(
    parameter int unsigned             ADDR_W      = 32,
    parameter int unsigned             NUM_SLV     = 3,
    parameter logic [ADDR_W-1:0]       BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned             REGION_LOG2 = 26
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              hit_o
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] region;

    assign offset = addr_i - BASE_ADDR;
    assign region = offset >> REGION_LOG2;
    assign idx_o  = region[IDX_W-1:0];
    // The full-width region number is compared so addresses far above the
    // window never alias back onto a low index.
    assign hit_o  = (addr_i >= BASE_ADDR) && (region < ADDR_W'(NUM_SLV));

endmodule

// File: rtl/ahb2apb_bridge_p.sv
// ---------------------------------------------------------------------------
// ahb2apb_bridge_p
// AHB-Lite slave to APB3 bridge with NUM_SLV completers, PREADY wait states,
// PSLVERR and optional ACCESS watchdog mapped onto the two-cycle AHB ERROR.
// Ports:
//   Hclk, Hresetn               clock / async active-low reset
//   Htrans, Hwrite, Hreadyin,
//   Haddr, Hwdata               AHB request inputs
//   Hrdata, Hreadyout, Hresp    AHB response outputs
//   Psel, Penable, Pwrite,
//   Paddr, Pwdata               APB request outputs
//   Prdata, Pready, Pslverr     APB response inputs (Prdata muxed externally)
//   dbg_state_o                 current FSM state (ahb_apb_pkg::state_e)
// Handshake: an AHB transfer is accepted on a rising edge where Hreadyout=1,
// Hreadyin=1 and Htrans is NONSEQ/SEQ; an APB access completes on a rising
// edge where Psel/Penable are high and Pready=1.
// ---------------------------------------------------------------------------
module ahb2apb_bridge_p
    import ahb_apb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_SLV     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned       REGION_LOG2 = 26,
    parameter int unsigned       TIMEOUT     = 0
) (
    input  logic                Hclk,
    input  logic                Hresetn,
    input  logic [1:0]          Htrans,
    input  logic                Hwrite,
    input  logic                Hreadyin,
    input  logic [ADDR_W-1:0]   Haddr,
    input  logic [DATA_W-1:0]   Hwdata,
    output logic [DATA_W-1:0]   Hrdata,
    output logic                Hreadyout,
    output logic [1:0]          Hresp,
    output logic [NUM_SLV-1:0]  Psel,
    output logic                Penable,
    output logic                Pwrite,
    output logic [ADDR_W-1:0]   Paddr,
    output logic [DATA_W-1:0]   Pwdata,
    input  logic [DATA_W-1:0]   Prdata,
    input  logic                Pready,
    input  logic                Pslverr,
    output logic [2:0]          dbg_state_o
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [WD_W-1:0]     wdog_q, wdog_d;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                ready_phase;
    logic                sample;
    logic                timeout_hit;
    logic [NUM_SLV-1:0]  sel_onehot;

    apb_region_decoder #(
        .ADDR_W      (ADDR_W),
        .NUM_SLV     (NUM_SLV),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_LOG2 (REGION_LOG2)
    ) u_dec (
        .addr_i (Haddr),
        .idx_o  (dec_idx),
        .hit_o  (dec_hit)
    );

    // The bridge only looks at the address phase while it is itself ready.
    assign ready_phase = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign sample      = ready_phase && xfer_valid(Htrans, Hreadyin);
    // wdog_q counts completed not-ready ACCESS cycles, so the abort fires on
    // the TIMEOUT-th one.
    assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WD_W'(TIMEOUT - 1));
    assign sel_onehot  = NUM_SLV'(1) << idx_q;

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (sample) begin
                    if (!dec_hit)    state_d = ST_ERR1;
                    else if (Hwrite) state_d = ST_WDATA;
                    else             state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: state_d = ST_SETUP;
            ST_SETUP: begin
                state_d = ST_ACCESS;
                wdog_d  = '0;
            end
            ST_ACCESS: begin
                if (Pready)           state_d = Pslverr ? ST_ERR1 : ST_DONE;
                else if (timeout_hit) state_d = ST_ERR1;
                else                  wdog_d  = wdog_q + WD_W'(1);
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            if (sample) begin
                addr_q  <= Haddr;
                write_q <= Hwrite;
                idx_q   <= dec_idx;
            end
            // Hwdata belongs to the data phase, i.e. the cycle after sampling.
            if (state_q == ST_WDATA) begin
                wdata_q <= Hwdata;
            end
            if ((state_q == ST_ACCESS) && Pready && !Pslverr && !write_q) begin
                rdata_q <= Prdata;
            end
        end
    end

    // Bus outputs decode straight from state so reset drops them at once.
    always_comb begin
        Hreadyout   = ready_phase;
        Hresp       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        Psel        = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_onehot : '0;
        Penable     = (state_q == ST_ACCESS);
        Pwrite      = write_q;
        Paddr       = addr_q;
        Pwdata      = wdata_q;
        Hrdata      = rdata_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_ahb2apb_bridge_p.sv
module tb_ahb2apb_bridge_p;
    import ahb_apb_pkg::*;

    logic        Hclk;
    logic        Hresetn;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic        Hreadyin;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Hrdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [2:0]  Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_rdata;

    ahb2apb_bridge_p #(
        .TIMEOUT (4)
    ) dut (
        .Hclk        (Hclk),
        .Hresetn     (Hresetn),
        .Htrans      (Htrans),
        .Hwrite      (Hwrite),
        .Hreadyin    (Hreadyin),
        .Haddr       (Haddr),
        .Hwdata      (Hwdata),
        .Hrdata      (Hrdata),
        .Hreadyout   (Hreadyout),
        .Hresp       (Hresp),
        .Psel        (Psel),
        .Penable     (Penable),
        .Pwrite      (Pwrite),
        .Paddr       (Paddr),
        .Pwdata      (Pwdata),
        .Prdata      (Prdata),
        .Pready      (Pready),
        .Pslverr     (Pslverr),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] prd;
        logic [2:0]  psel;
        logic [1:0]  resp;
        int          cycles;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: transaction-level outcome from the address map and
    // the completer's behaviour (waits = not-ready ACCESS cycles).
    task automatic predict(input logic wr, input logic [31:0] addr, input int waits,
                           input logic err, input logic [31:0] prd,
                           output logic [2:0] psel, output logic [1:0] resp,
                           output int cycles);
        longint a, region;
        int     extra;
        a      = longint'(addr);
        region = (a - 64'h8000_0000) / (64'd1 << 26);
        extra  = wr ? 1 : 0;
        if (a < 64'h8000_0000 || region >= 3) begin
            psel = 3'b000; resp = 2'b01; cycles = 2;
        end else begin
            psel = 3'b001 << region;
            if (waits >= 4) begin
                resp = 2'b01; cycles = extra + 1 + 4 + 2;
            end else if (err) begin
                resp = 2'b01; cycles = extra + 1 + (waits + 1) + 2;
            end else begin
                resp = 2'b00; cycles = extra + 1 + (waits + 1) + 1;
                if (!wr) model_rdata = prd;
            end
        end
    endtask

    // ---------------- driver + APB completer ----------------
    // Called away from a rising edge; returns at the falling edge of the
    // completion cycle so a following call overlaps the next address phase.
    task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic err,
                        input logic [31:0] prd, input logic [2:0] exp_psel,
                        input logic [1:0] exp_resp, input int exp_cycles,
                        input logic [31:0] exp_rdata);
        int         cycles;
        int         acc_cnt;
        logic [2:0] psel_or;
        logic [1:0] prev_resp;
        logic       apb_ok;
        logic       seen_psel;
        logic       done;
        logic       rdy;
        cycles = 0; acc_cnt = 0; psel_or = '0; prev_resp = '0;
        apb_ok = 1'b1; seen_psel = 1'b0; done = 1'b0;
        Htrans = HTRANS_NONSEQ; Hwrite = wr; Haddr = addr; Hreadyin = 1'b1;
        @(posedge Hclk); #1;
        Htrans = HTRANS_IDLE; Hwdata = wdata;
        while (!done && cycles < 100) begin
            @(negedge Hclk);
            cycles++;
            if (Hreadyout) begin
                done = 1'b1;
            end else begin
                prev_resp = Hresp;
                psel_or |= Psel;
                if (Penable && Psel == 3'b000) apb_ok = 1'b0;
                if (Psel != 3'b000) begin
                    if (Paddr !== addr || Pwrite !== wr) apb_ok = 1'b0;
                    if (wr && Pwdata !== wdata) apb_ok = 1'b0;
                    if (!seen_psel && Penable) apb_ok = 1'b0;
                    seen_psel = 1'b1;
                end
                if (Penable) begin
                    rdy     = (acc_cnt >= waits);
                    Pready  = rdy;
                    Pslverr = err && rdy;
                    Prdata  = rdy ? prd : ~prd;
                    acc_cnt++;
                end else begin
                    Pready = 1'b0; Pslverr = 1'b0;
                end
            end
        end
        Pready = 1'b0; Pslverr = 1'b0;
        check({name, ".complete"}, 64'(done), 64'(1));
        check({name, ".cycles"}, 64'(cycles), 64'(exp_cycles));
        check({name, ".resp"}, {60'd0, prev_resp, Hresp}, {60'd0, exp_resp, exp_resp});
        check({name, ".rdata"}, 64'(Hrdata), 64'(exp_rdata));
        check({name, ".psel"}, 64'(psel_or), 64'(exp_psel));
        check({name, ".apb_fields"}, 64'(apb_ok), 64'(1));
        check({name, ".bus_idle"}, {60'd0, Psel, Penable}, 64'(0));
    endtask

    // ---------------- test ----------------
    initial begin
        logic [2:0]  e_psel;
        logic [1:0]  e_resp;
        int          e_cyc;
        logic        r_wr, r_err;
        logic [31:0] r_addr, r_wdata, r_prd;
        int          r_waits, region, guard;

        tbl[0]  = '{1'b0, 32'h8400_0010, 32'h0,         0,  1'b0, 32'hDEAD_BEEF, 3'b010, 2'b00, 3, 32'hDEAD_BEEF};
        tbl[1]  = '{1'b1, 32'h8800_0004, 32'h1234_5678, 2,  1'b0, 32'h0,         3'b100, 2'b00, 6, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 32'h8C00_0000, 32'h0,         0,  1'b0, 32'h0,         3'b000, 2'b01, 2, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 32'h8000_0100, 32'h0000_A5A5, 1,  1'b1, 32'h0,         3'b001, 2'b01, 6, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b0, 32'h8000_0000, 32'h0,         0,  1'b1, 32'h0BAD_F00D, 3'b001, 2'b01, 4, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 32'h8BFF_FFFC, 32'h0,         3,  1'b0, 32'h1111_2222, 3'b100, 2'b00, 6, 32'h1111_2222};
        tbl[6]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         0,  1'b0, 32'h0,         3'b000, 2'b01, 2, 32'h1111_2222};
        tbl[7]  = '{1'b1, 32'h8400_0000, 32'h7777_0000, 10, 1'b0, 32'h0,         3'b010, 2'b01, 8, 32'h1111_2222};
        tbl[8]  = '{1'b0, 32'h8000_0040, 32'h0,         6,  1'b0, 32'h3333_4444, 3'b001, 2'b01, 7, 32'h1111_2222};
        tbl[9]  = '{1'b0, 32'h8400_0020, 32'h0,         0,  1'b0, 32'hCAFE_0001, 3'b010, 2'b00, 3, 32'hCAFE_0001};
        tbl[10] = '{1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 0,  1'b0, 32'h0,         3'b000, 2'b01, 2, 32'hCAFE_0001};

        Hresetn = 1'b0; Htrans = HTRANS_IDLE; Hwrite = 1'b0; Hreadyin = 1'b1;
        Haddr = '0; Hwdata = '0; Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
        repeat (3) @(negedge Hclk);
        check("reset.hready_resp", {61'd0, Hreadyout, Hresp}, 64'h4);
        check("reset.apb", {Psel, Penable, Pwrite}, 64'(0));
        check("reset.paddr_pwdata", {Paddr, Pwdata}, 64'(0));
        check("reset.hrdata", 64'(Hrdata), 64'(0));
        check("reset.state", 64'(dbg_state), 64'(ST_IDLE));
        Hresetn = 1'b1;
        @(negedge Hclk);

        // Directed table, issued back to back.
        for (int i = 0; i < 11; i++) begin
            xfer($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits,
                 tbl[i].err, tbl[i].prd, tbl[i].psel, tbl[i].resp, tbl[i].cycles, tbl[i].rdata);
        end
        model_rdata = 32'hCAFE_0001;

        // Transfers that must be ignored: Hreadyin low, then BUSY.
        @(negedge Hclk);
        Htrans = HTRANS_NONSEQ; Hreadyin = 1'b0; Haddr = 32'h8000_0000; Hwrite = 1'b0;
        repeat (2) begin
            @(negedge Hclk);
            check("ignore.hreadyin_low", {60'd0, Hreadyout, Psel}, 64'h8);
        end
        Htrans = HTRANS_BUSY; Hreadyin = 1'b1;
        repeat (2) begin
            @(negedge Hclk);
            check("ignore.busy", {60'd0, Hreadyout, Psel}, 64'h8);
        end
        Htrans = HTRANS_IDLE;

        // Reset while in ACCESS.
        @(negedge Hclk);
        Htrans = HTRANS_NONSEQ; Haddr = 32'h8000_0008; Hwrite = 1'b0;
        @(posedge Hclk); #1;
        Htrans = HTRANS_IDLE;
        guard = 0;
        do begin
            @(negedge Hclk);
            guard++;
        end while (!Penable && guard < 10);
        check("rstmid.reach_access", 64'(Penable), 64'(1));
        #2 Hresetn = 1'b0;
        #1;
        check("rstmid.apb_drop", {Psel, Penable, Pwrite}, 64'(0));
        check("rstmid.ahb", {29'd0, Hreadyout, Hresp, Hrdata}, {29'd0, 1'b1, 2'b00, 32'h0});
        check("rstmid.paddr_pwdata", {Paddr, Pwdata}, 64'(0));
        @(negedge Hclk);
        Hresetn = 1'b1;
        @(negedge Hclk);
        model_rdata = 32'h0;
        xfer("post_reset_read", 1'b0, 32'h8400_0004, 32'h0, 0, 1'b0, 32'h5555_AAAA,
             3'b010, 2'b00, 3, 32'h5555_AAAA);
        model_rdata = 32'h5555_AAAA;

        // Randomized transfers against the model.
        for (int n = 0; n < 40; n++) begin
            region  = $urandom_range(0, 4);
            r_wr    = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            r_prd   = $urandom;
            r_waits = $urandom_range(0, 5);
            r_err   = ($urandom_range(0, 3) == 0);
            if (region < 4) r_addr = 32'h8000_0000 + (32'(region) << 26) + ($urandom & 32'h03FF_FFFC);
            else            r_addr = $urandom & 32'h7FFF_FFFC;
            if ($urandom_range(0, 9) == 0) r_addr = $urandom | 32'hC000_0000;
            predict(r_wr, r_addr, r_waits, r_err, r_prd, e_psel, e_resp, e_cyc);
            xfer($sformatf("rnd%0d", n), r_wr, r_addr, r_wdata, r_waits, r_err, r_prd,
                 e_psel, e_resp, e_cyc, model_rdata);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge Hclk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
